dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the pipelined ARM core's data port. It answers the core's MEM-stage accesses (address, write strobe, write data, read data) from an on-chip word array, and adds a small memory-mapped control window. A host fills the array through a valid/ready loader stream, the block raises the core's `start`, and it signals completion when the program writes the DONE register.

## Interface

Parameters:
- DEPTH, 256: data words in the array; must be a power of two.
- MMIO_BASE, 32'h0000_0400: byte address of the control window; must lie above DEPTH*4.

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- cpu_addr, in, 32: byte address from the core (ALUResult).
- cpu_wdata, in, 32: store data from the core (WriteData).
- cpu_we, in, 1: store strobe from the core (MemWrite).
- cpu_rdata, out, 32: load data to the core (ReadData); combinational.
- cpu_start, out, 1: run enable to the core's `start` input.
- load_valid, in, 1: loader word valid.
- load_ready, out, 1: loader word accepted this cycle.
- load_data, in, 32: loader word.
- load_last, in, 1: marks the final loader word.
- done, out, 1: the program has finished.
- result, out, 32: value the program wrote to DONE.
- cycles, out, 32: number of RUN cycles in the last or current run.
- host_ack, in, 1: host releases DONE and returns the block to IDLE.

## Operation

- FSM states: IDLE, LOAD, RUN, DONE. Reset forces IDLE.
- Reset values: wptr=0, cycles=0, result=0, done=0, cpu_start=0, load_ready=0. The array is not reset.
- IDLE:
  - load_ready=1.
  - A handshake writes mem[0] and sets wptr=1.
  - If load_last is set on that handshake, go to RUN; otherwise go to LOAD.
- LOAD:
  - load_ready=1.
  - Each handshake (load_valid & load_ready) writes mem[wptr] and increments wptr.
  - Go to RUN on a handshake with load_last, or on a handshake when wptr==DEPTH-1 (array full; load_last is not required).
- RUN:
  - cpu_start=1 and load_ready=0.
  - cycles increments every cycle; it is cleared on entry to RUN.
  - Word index is cpu_addr[log2(DEPTH)+1:2]; cpu_addr[1:0] is ignored.
  - In-range read (cpu_addr < DEPTH*4): cpu_rdata = mem[index], same cycle.
  - In-range write: on the clock edge when cpu_we=1.
  - Read at MMIO_BASE returns {31'b0, done}. Read at MMIO_BASE+4 returns cycles.
  - Write at MMIO_BASE captures cpu_wdata into result, sets done=1 and moves to DONE.
  - All other addresses read 32'h0; writes to them are dropped.
- DONE:
  - cpu_start=0, done=1, cycles frozen.
  - cpu_we is ignored; reads still decode normally.
  - host_ack moves to IDLE, clearing done and wptr; result and cycles are held.
- cpu_we is ignored outside RUN.

## Timing

- Load path is one word per cycle at full throughput.
- cpu_start rises the cycle after the terminating handshake.
- Read latency to the core is zero cycles (combinational through the MEM stage). Write takes effect at the next edge.
- The DONE write is seen on its edge: done=1 and cpu_start=0 in the following cycle.
- If host_ack and load_valid are both high in DONE, host_ack wins and load_ready stays 0 that cycle.
- Reset mid-LOAD or mid-RUN returns to IDLE immediately and asynchronously. cpu_start drops without waiting for a clock edge. Array contents are undefined for verification purposes.

## Structure

- Shared package dmem_pkg holds:
  - the state enum,
  - the MMIO offset constants DONE_OFS=0 and CYCLES_OFS=4,
  - an address-region decode function.
- One sub-module, dmem_array: synchronous-write, asynchronous-read word RAM with a single write port. The write port is muxed between the loader and the core by state.

## Test plan

- Load 3 words (1,2,3) with load_last on the 3rd → cpu_start=1 next cycle. Reads at byte addresses 0, 4, 8 return 1, 2, 3. Address 9 returns 3 (byte bits ignored).
- In RUN, write 0xDEAD at address 0x10, then read 0x10 → 0xDEAD. Write at 0x3FC0 (out of range) → a read there returns 0.
- After 5 RUN cycles, write 0x2A to MMIO_BASE → next cycle done=1, result=0x2A, cpu_start=0, cycles=5. A later cpu_we has no effect.
- Stream DEPTH words with load_last never set → RUN is entered after word DEPTH-1. load_ready is 0 from then on.
- In DONE, assert host_ack and load_valid together → IDLE, with no word accepted that cycle. The next handshake writes mem[0].
- Assert reset low mid-LOAD at wptr=7 → IDLE, wptr=0, cpu_start=0, without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and address decode for the core data-port responder.
// Latency: none (types/functions only); backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    REG_MEM,
    REG_DONE,
    REG_CYCLES,
    REG_NONE
  } region_e;

  localparam logic [31:0] DONE_OFS   = 32'h0000_0000;
  localparam logic [31:0] CYCLES_OFS = 32'h0000_0004;

  // MMIO registers match on the full byte address; the RAM window is everything below mem_bytes.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] mem_bytes,
                                            input logic [31:0] mmio_base);
    region_e r;
    if (addr < mem_bytes) begin
      r = REG_MEM;
    end else if (addr == mmio_base + DONE_OFS) begin
      r = REG_DONE;
    end else if (addr == mmio_base + CYCLES_OFS) begin
      r = REG_CYCLES;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM, one synchronous write port and one asynchronous read port, no reset.
// Latency: read 0 cycles, write lands on the next edge; backpressure: none.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: host loads the word array, core runs against it, DONE register ends the run.
// Latency: reads 0 cycles, writes next edge; loader accepts one word per cycle in IDLE/LOAD only.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cycles,
  input  logic        host_ack
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   result_q, result_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] word_idx;
  region_e       region;

  assign word_idx = cpu_addr[AW+1:2];
  assign region   = decode_region(cpu_addr, MEM_BYTES, MMIO_BASE);

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (word_idx),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      cycles_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      cycles_q <= cycles_d;
      result_q <= result_d;
    end
  end

  // load_ready is qualified by reset so it reads 0 while reset is held.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cycles_d   = cycles_q;
    result_d   = result_q;
    mem_we     = 1'b0;
    mem_waddr  = wptr_q;
    mem_wdata  = load_data;
    load_ready = 1'b0;
    cpu_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = reset;
        if (load_valid && load_ready) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wptr_d    = AW'(1);
          if (load_last) begin
            state_d  = RUN;
            cycles_d = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        load_ready = reset;
        if (load_valid && load_ready) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (load_last || (wptr_q == AW'(DEPTH - 1))) begin
            state_d  = RUN;
            cycles_d = '0;
          end
        end
      end
      RUN: begin
        cpu_start = 1'b1;
        cycles_d  = cycles_q + 32'd1;
        if (cpu_we) begin
          if (region == REG_MEM) begin
            mem_we    = 1'b1;
            mem_waddr = word_idx;
            mem_wdata = cpu_wdata;
          end else if (region == REG_DONE) begin
            result_d = cpu_wdata;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (host_ack) begin
          state_d = IDLE;
          wptr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_rdata = 32'h0;
    unique case (region)
      REG_MEM:    cpu_rdata = mem_rdata;
      REG_DONE:   cpu_rdata = {31'b0, done};
      REG_CYCLES: cpu_rdata = cycles_q;
      default:    cpu_rdata = 32'h0;
    endcase
  end

  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, randomized traffic against a word-array model,
// and hand sequences for load termination, DONE handling and asynchronous reset.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] MMIO  = 32'h0000_0400;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_start;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        done;
  logic [31:0] result;
  logic [31:0] cycles;
  logic        host_ack;

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .cpu_start  (cpu_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .done       (done),
    .result     (result),
    .cycles     (cycles),
    .host_ack   (host_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  int          n_chk;
  int          n_pass;
  logic [31:0] mdl [DEPTH];
  int unsigned rc;
  vec_t        tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    #1 chk("load_accept", {30'b0, cpu_start, load_ready}, 32'b01);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic done_write(input logic [31:0] v);
    cpu_addr  = MMIO;
    cpu_we    = 1'b1;
    cpu_wdata = v;
    tick();
    rc++;
    cpu_we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned op, idx;
    logic [31:0] v, e;
    n_chk = 0;
    n_pass = 0;
    rc = 0;
    tbl[0]  = '{32'h0000_0000, 32'h0,      1'b0, 1'b1, 32'd1};
    tbl[1]  = '{32'h0000_0004, 32'h0,      1'b0, 1'b1, 32'd2};
    tbl[2]  = '{32'h0000_0008, 32'h0,      1'b0, 1'b1, 32'd3};
    tbl[3]  = '{32'h0000_0009, 32'h0,      1'b0, 1'b1, 32'd3};
    tbl[4]  = '{32'h0000_0010, 32'hDEAD,   1'b1, 1'b0, 32'h0};
    tbl[5]  = '{32'h0000_0010, 32'h0,      1'b0, 1'b1, 32'hDEAD};
    tbl[6]  = '{32'h0000_3FC0, 32'h1234,   1'b1, 1'b0, 32'h0};
    tbl[7]  = '{32'h0000_3FC0, 32'h0,      1'b0, 1'b1, 32'h0};
    tbl[8]  = '{MMIO + 32'h4,  32'h0,      1'b0, 1'b1, 32'd8};
    tbl[9]  = '{MMIO,          32'h0,      1'b0, 1'b1, 32'd0};
    tbl[10] = '{MMIO + 32'h8,  32'h0,      1'b0, 1'b1, 32'd0};

    reset = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; host_ack = 1'b0;
    #3;
    chk("rst_start", {31'b0, cpu_start}, 32'd0);
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    tick(); tick();
    #2 reset = 1'b1;
    #1 chk("idle_ready", {31'b0, load_ready}, 32'd1);
    tick();

    // Seven words in, then reset lands mid-cycle.
    for (int i = 0; i < 7; i++) push(32'(i + 100), 1'b0);
    #2 reset = 1'b0;
    #1 chk("mid_load_rst_ready", {31'b0, load_ready}, 32'd0);
    chk("mid_load_rst_start", {31'b0, cpu_start}, 32'd0);
    #2 reset = 1'b1;
    tick();

    // Full array without load_last: the DEPTH-th word terminates the load.
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom;
      mdl[i] = v;
      push(v, 1'b0);
    end
    #1 chk("full_run_state", {30'b0, cpu_start, load_ready}, 32'b10);
    chk("run_entry_cycles", cycles, 32'd0);
    rc = 0;

    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, DEPTH - 1);
      v   = $urandom;
      cpu_we = 1'b0;
      cpu_wdata = v;
      if (op <= 3) begin
        cpu_addr = idx * 4 + $urandom_range(0, 3);
        e = mdl[idx];
      end else if (op <= 6) begin
        cpu_addr = idx * 4;
        cpu_we = 1'b1;
        e = mdl[idx];
      end else if (op == 7) begin
        cpu_addr = 32'h0000_0800 + ($urandom_range(0, 32'h7FFF_0000) & 32'hFFFF_FFFC);
        cpu_we = 1'($urandom_range(0, 1));
        e = 32'h0;
      end else if (op == 8) begin
        cpu_addr = MMIO + 32'h4;
        e = rc;
      end else begin
        cpu_addr = MMIO;
        e = 32'h0;
      end
      #1 chk("rand_rd", cpu_rdata, e);
      tick();
      rc++;
      if (op >= 4 && op <= 6) mdl[idx] = v;
    end
    cpu_we = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cpu_addr = 32'(i) * 4;
      #1 chk("sweep_rd", cpu_rdata, mdl[i]);
      tick();
      rc++;
    end

    v = $urandom;
    done_write(v);
    cpu_addr = MMIO;
    #1 chk("done_flag", {31'b0, done}, 32'd1);
    chk("done_start", {31'b0, cpu_start}, 32'd0);
    chk("done_result", result, v);
    chk("done_cycles", cycles, rc);
    chk("done_mmio_rd", cpu_rdata, 32'd1);

    cpu_addr = 32'd12; cpu_we = 1'b1; cpu_wdata = ~mdl[3];
    tick();
    cpu_addr = MMIO; cpu_wdata = v ^ 32'h1;
    tick();
    cpu_we = 1'b0; cpu_addr = 32'd12;
    #1 chk("done_we_mem", cpu_rdata, mdl[3]);
    chk("done_we_result", result, v);
    chk("done_cycles_frozen", cycles, rc);

    host_ack = 1'b1; load_valid = 1'b1; load_data = 32'hBAD0_BAD0; load_last = 1'b1;
    cpu_addr = 32'd0;
    #1 chk("ack_ready", {31'b0, load_ready}, 32'd0);
    tick();
    host_ack = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    #1 chk("ack_idle", {29'b0, done, cpu_start, load_ready}, 32'b001);
    chk("ack_result_held", result, v);
    chk("ack_cycles_held", cycles, rc);
    chk("ack_no_write", cpu_rdata, mdl[0]);

    push(32'd1, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b1);
    #1 chk("short_start", {31'b0, cpu_start}, 32'd1);
    rc = 0;
    for (int k = 0; k < 11; k++) begin
      cpu_addr = tbl[k].addr;
      cpu_wdata = tbl[k].wdata;
      cpu_we = tbl[k].we;
      #1 if (tbl[k].chk) chk($sformatf("vec%0d", k), cpu_rdata, tbl[k].exp);
      tick();
      rc++;
    end
    done_write(32'h77);
    #1 chk("vec_cycles", cycles, rc);
    chk("vec_result", result, 32'h77);

    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    push(32'h55, 1'b1);
    cpu_addr = MMIO + 32'h4;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cyc_count", cpu_rdata, 32'(i));
      tick();
    end
    done_write(32'h2A);
    #1 chk("five_cycles", cycles, 32'd5);
    chk("five_result", result, 32'h2A);
    chk("five_state", {30'b0, done, cpu_start}, 32'b10);

    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    push(32'h9, 1'b1);
    #1 chk("rerun_start", {31'b0, cpu_start}, 32'd1);
    tick(); tick();
    #2 reset = 1'b0;
    #1 chk("mid_run_rst_start", {31'b0, cpu_start}, 32'd0);
    chk("mid_run_rst_cycles", cycles, 32'd0);
    chk("mid_run_rst_result", result, 32'd0);
    chk("mid_run_rst_done", {31'b0, done}, 32'd0);
    #2 reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
